// File: rtl/and_serial_if.sv
// Handshake/result bundle for the bit-serial AND engine.
// Master drives the request side, the engine (slave) drives everything else.
interface and_serial_if #(
  parameter int WIDTH = 4
) ();
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic [IW-1:0]    bit_idx;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b,
    input  ready, sout, sout_valid, bit_idx, done, result
  );

  modport slave (
    input  start, a, b,
    output ready, sout, sout_valid, bit_idx, done, result
  );
endinterface

// File: rtl/and_serial.sv
// Bit-serial AND engine: captures two operands, streams a&b LSB first,
// then publishes the assembled word with a one-cycle done pulse.
//
// state | meaning
// IDLE  | ready for a new start, outputs quiet
// SHIFT | one result bit on sout per cycle, bit_idx 0..WIDTH-1
// DONE  | result updated, done high for this single cycle
module and_serial #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  and_serial_if.slave  bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic             r_ready;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_done;

  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;

  assign w_accept   = bus.start & r_ready;
  // The bit currently on sout enters from the MSB end, so after WIDTH
  // shifts bit 0 has landed in the LSB position.
  assign w_acc_next = {r_sout, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_result     <= '0;
      r_idx        <= '0;
      r_ready      <= 1'b1;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_a          <= bus.a;
            r_b          <= bus.b;
            r_acc        <= '0;
            r_sout       <= bus.a[0] & bus.b[0];
            r_sout_valid <= 1'b1;
            r_idx        <= '0;
            r_ready      <= 1'b0;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc <= w_acc_next;
          if (r_idx == LAST_IDX) begin
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_idx        <= '0;
            r_result     <= w_acc_next;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sout  <= r_a[1] & r_b[1];
            r_idx   <= r_idx + IW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done       <= 1'b0;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_idx        <= '0;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = r_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.bit_idx    = r_idx;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
endmodule

// File: tb/tb_and_serial.sv
// Bench for and_serial: WIDTH=4 and WIDTH=8 instances checked every cycle
// against a timeline model (cycles since accept), plus directed literal cases.
module tb_and_serial;
  logic clk;
  logic rst_n;

  and_serial_if #(.WIDTH(4)) if4 ();
  and_serial_if #(.WIDTH(8)) if8 ();

  and_serial #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  and_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int n_cmp = 0;
  int n_bad = 0;

  // model: m_t = edges since accept (-1 when idle)
  int         wid[2] = '{4, 8};
  int         m_t[2];
  logic [7:0] m_val[2];
  logic [7:0] m_res[2];
  int         m_acc[2];
  int         m_abort[2];
  int         dut_done[2];

  logic       s_rst;
  logic       s_start[2];
  logic [7:0] s_a[2];
  logic [7:0] s_b[2];

  task automatic chk(input string nm, input int w, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (W=%0d): got 0x%0h, expected 0x%0h", nm, w, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-cycle compare process
  initial begin
    logic [31:0] a_rdy, a_so, a_sv, a_idx, a_dn, a_res;
    logic        e_sv;
    logic        e_so;
    int          e_idx;
    for (int d = 0; d < 2; d++) begin
      m_t[d] = -1; m_val[d] = '0; m_res[d] = '0;
      m_acc[d] = 0; m_abort[d] = 0; dut_done[d] = 0;
    end
    forever begin
      @(posedge clk);
      s_rst      = rst_n;
      s_start[0] = if4.start;
      s_a[0]     = {4'h0, if4.a};
      s_b[0]     = {4'h0, if4.b};
      s_start[1] = if8.start;
      s_a[1]     = if8.a;
      s_b[1]     = if8.b;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!s_rst || !rst_n) begin
          if (m_t[d] >= 0 && m_t[d] < wid[d]) m_abort[d]++;
          m_t[d]   = -1;
          m_res[d] = '0;
        end else if (m_t[d] < 0) begin
          if (s_start[d]) begin
            m_t[d]   = 0;
            m_val[d] = s_a[d] & s_b[d];
            m_acc[d]++;
          end
        end else begin
          m_t[d]++;
          if (m_t[d] == wid[d]) m_res[d] = m_val[d];
          else if (m_t[d] == wid[d] + 1) m_t[d] = -1;
        end
        e_sv  = (m_t[d] >= 0) && (m_t[d] < wid[d]);
        e_so  = e_sv ? m_val[d][m_t[d]] : 1'b0;
        e_idx = e_sv ? m_t[d] : 0;
        if (d == 0) begin
          a_rdy = 32'(if4.ready); a_so = 32'(if4.sout); a_sv = 32'(if4.sout_valid);
          a_idx = 32'(if4.bit_idx); a_dn = 32'(if4.done); a_res = 32'(if4.result);
        end else begin
          a_rdy = 32'(if8.ready); a_so = 32'(if8.sout); a_sv = 32'(if8.sout_valid);
          a_idx = 32'(if8.bit_idx); a_dn = 32'(if8.done); a_res = 32'(if8.result);
        end
        chk("cyc_ready",      wid[d], a_rdy, 32'(m_t[d] < 0));
        chk("cyc_sout",       wid[d], a_so,  32'(e_so));
        chk("cyc_sout_valid", wid[d], a_sv,  32'(e_sv));
        chk("cyc_bit_idx",    wid[d], a_idx, 32'(e_idx));
        chk("cyc_done",       wid[d], a_dn,  32'(m_t[d] == wid[d]));
        chk("cyc_result",     wid[d], a_res, 32'(m_res[d]));
        if (a_dn == 32'd1) dut_done[d]++;
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Start a WIDTH=4 op from idle, gather the serial bits and the final result.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      output logic [3:0] seq, output logic [3:0] res,
                      output int idx_bad, output logic dn);
    @(negedge clk); #1;
    if4.start = 1'b1; if4.a = a; if4.b = b;
    idx_bad = 0;
    for (int k = 0; k < 4; k++) begin
      edge1();
      if (k == 0) if4.start = 1'b0;
      seq[k] = if4.sout;
      if (int'(if4.bit_idx) != k) idx_bad++;
    end
    edge1();
    dn  = if4.done;
    res = if4.result;
    edge1();
  endtask

  initial begin
    logic [3:0] seq4, res4;
    logic [7:0] seq8;
    logic       dn;
    int         ibad, ndone, guard;
    int         base0, base1;

    rst_n = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    edge1();
    chk("rst_ready",  4, 32'(if4.ready), 32'd1);
    chk("rst_valid",  4, 32'(if4.sout_valid), 32'd0);
    chk("rst_done",   8, 32'(if8.done), 32'd0);
    chk("rst_result", 8, 32'(if8.result), 32'd0);
    repeat (2) edge1();
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) edge1();

    // 1011 & 0110
    run4(4'b1011, 4'b0110, seq4, res4, ibad, dn);
    chk("t1_seq", 4, 32'(seq4), 32'h2);
    chk("t1_idx", 4, 32'(ibad), 32'd0);
    chk("t1_done", 4, 32'(dn), 32'd1);
    chk("t1_result", 4, 32'(res4), 32'h2);
    chk("t1_ready", 4, 32'(if4.ready), 32'd1);

    // start held high across two operations
    @(negedge clk); #1;
    if4.start = 1'b1; if4.a = 4'hF; if4.b = 4'hF;
    for (int k = 0; k < 4; k++) begin
      edge1();
      if (k == 0) if4.a = 4'h0;
      seq4[k] = if4.sout;
    end
    chk("t2_seq1", 4, 32'(seq4), 32'hF);
    edge1();
    chk("t2_done1", 4, 32'(if4.done), 32'd1);
    chk("t2_res1", 4, 32'(if4.result), 32'hF);
    edge1();
    chk("t2_ready", 4, 32'(if4.ready), 32'd1);
    edge1();
    chk("t2_accept2", 4, 32'(if4.sout_valid), 32'd1);
    chk("t2_res_hold", 4, 32'(if4.result), 32'hF);
    if4.start = 1'b0;
    repeat (4) edge1();
    chk("t2_done2", 4, 32'(if4.done), 32'd1);
    chk("t2_res2", 4, 32'(if4.result), 32'h0);
    edge1();

    // start and operand changes during SHIFT are ignored
    @(negedge clk); #1;
    if4.start = 1'b1; if4.a = 4'hC; if4.b = 4'hA;
    for (int k = 0; k < 4; k++) begin
      edge1();
      seq4[k] = if4.sout;
      if (k == 0) if4.start = 1'b0;
      if (k == 1) begin if4.start = 1'b1; if4.a = 4'h0; if4.b = 4'h0; end
      if (k == 2) if4.start = 1'b0;
    end
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      edge1();
      if (if4.done) ndone++;
      if (k == 0) res4 = if4.result;
    end
    chk("t3_seq", 4, 32'(seq4), 32'h8);
    chk("t3_result", 4, 32'(res4), 32'h8);
    chk("t3_ndone", 4, 32'(ndone), 32'd1);

    // async reset mid-shift
    @(negedge clk); #1;
    if4.start = 1'b1; if4.a = 4'h7; if4.b = 4'h7;
    edge1();
    if4.start = 1'b0;
    repeat (2) edge1();
    rst_n = 1'b0;
    #1;
    chk("t4_valid", 4, 32'(if4.sout_valid), 32'd0);
    chk("t4_ready", 4, 32'(if4.ready), 32'd1);
    chk("t4_result", 4, 32'(if4.result), 32'h0);
    chk("t4_sout", 4, 32'(if4.sout), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      edge1();
      if (if4.done) ndone++;
    end
    chk("t4_no_done", 4, 32'(ndone), 32'd0);
    run4(4'h7, 4'h3, seq4, res4, ibad, dn);
    chk("t4_fresh_seq", 4, 32'(seq4), 32'h3);
    chk("t4_fresh_res", 4, 32'(res4), 32'h3);
    chk("t4_fresh_done", 4, 32'(dn), 32'd1);

    // WIDTH=8
    @(negedge clk); #1;
    if8.start = 1'b1; if8.a = 8'hA5; if8.b = 8'h3C;
    ibad = 0;
    for (int k = 0; k < 8; k++) begin
      edge1();
      if (k == 0) if8.start = 1'b0;
      seq8[k] = if8.sout;
      if (int'(if8.bit_idx) != k) ibad++;
    end
    chk("t5_seq", 8, 32'(seq8), 32'h24);
    chk("t5_idx", 8, 32'(ibad), 32'd0);
    edge1();
    chk("t5_done", 8, 32'(if8.done), 32'd1);
    chk("t5_result", 8, 32'(if8.result), 32'h24);
    edge1();

    // random traffic on both instances
    base0 = m_acc[0];
    base1 = m_acc[1];
    fork
      begin
        guard = 0;
        while (m_acc[0] - base0 < 1000 && guard < 40000) begin
          @(negedge clk); #1;
          if4.start = 1'($urandom_range(0, 1));
          if4.a = 4'($urandom);
          if4.b = 4'($urandom);
          guard++;
        end
        if4.start = 1'b0;
        chk("rand4_ops", 4, 32'(m_acc[0] - base0 >= 1000), 32'd1);
      end
      begin
        int g8;
        g8 = 0;
        while (m_acc[1] - base1 < 400 && g8 < 40000) begin
          @(negedge clk); #1;
          if8.start = 1'($urandom_range(0, 1));
          if8.a = 8'($urandom);
          if8.b = 8'($urandom);
          g8++;
        end
        if8.start = 1'b0;
        chk("rand8_ops", 8, 32'(m_acc[1] - base1 >= 400), 32'd1);
      end
    join
    repeat (20) edge1();
    chk("done_count", 4, 32'(dut_done[0]), 32'(m_acc[0] - m_abort[0]));
    chk("done_count", 8, 32'(dut_done[1]), 32'(m_acc[1] - m_abort[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/and_serial.md
# and_serial

Bit-serial AND engine: accepts two parallel WIDTH-bit operands on a start strobe, emits their bitwise AND one bit per clock (LSB first) on a serial output, and presents the assembled parallel result with a one-cycle done pulse. It is the serial-side counterpart to the parallel bitwise AND unit. It sits between the datapath and narrow serial links or scan-style result collectors, trading latency for a single-wire result path.

## Interface
- WIDTH, 4: operand/result width in bits; legal range WIDTH ≥ 2.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- ready  output  1  high in IDLE only; start accepted when start & ready at a rising edge.
- sout  output  1  current serial result bit, a[k] & b[k].
- sout_valid  output  1  high while sout carries a valid bit.
- bit_idx  output  $clog2(WIDTH)  index k of the bit on sout; 0 when sout_valid=0.
- done  output  1  one-cycle pulse, result complete.
- result  output  WIDTH  parallel a & b of the last completed operation; held until next done.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- Reset values: ready=1, sout=0, sout_valid=0, bit_idx=0, done=0, result=0; internal shift registers and counter cleared.
- IDLE: ready=1. On start & ready: capture a, b into shift registers; drive sout=a[0]&b[0], sout_valid=1, bit_idx=0; go SHIFT.
- SHIFT: ready=0. Each edge: shift operands right by one, increment bit_idx, drive next AND bit; each emitted bit also shifted into an accumulator from the MSB end. After bit WIDTH-1 has been presented for one cycle, next edge: sout_valid=0, sout=0, bit_idx=0, result<=accumulated value (equals captured a & b), done=1, go DONE.
- DONE: ready=0, done=1 for exactly this cycle. Next edge: done=0, go IDLE.
- start while ready=0: ignored, no effect on operation in progress, not queued.
- a, b changes after capture: no effect on current operation.
- result changes only on the edge that raises done; otherwise holds.
- Reset asserted in any state: all outputs and state return to reset values immediately (asynchronously); partial operation discarded, result=0.
- Counter: bit_idx counts 0..WIDTH-1, never wraps past WIDTH-1 within an operation.

## Timing
- Start accepted at edge T0.
- After edge T0+k, k=0..WIDTH-1: sout=a[k]&b[k], sout_valid=1, bit_idx=k, ready=0.
- After edge T0+WIDTH: done=1, result valid, sout_valid=0.
- After edge T0+WIDTH+1: done=0, ready=1.
- Earliest next accepted start: edge T0+WIDTH+2. Throughput one operation per WIDTH+2 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, a=4'b1011, b=4'b0110 -> sout 0,1,0,0 after edges T0..T0+3 with bit_idx 0..3, done pulse after T0+4, result=4'h2, ready high after T0+5.
- WIDTH=4, a=4'hF, b=4'hF, then a=4'h0, b=4'hF with start held high continuously -> first result 4'hF (sout 1,1,1,1), second start accepted at T0+6, second result 4'h0, result holds 4'hF until second done.
- Start pulsed and a/b changed to 4'h0 during SHIFT of a=4'hC, b=4'hA -> ignored; sout 0,0,0,1, result=4'h8, exactly one done.
- rst_n low at T0+2 mid-shift of a=4'h7, b=4'h7 -> immediately sout_valid=0, ready=1, result=0, no done; fresh start afterwards completes correctly.
- WIDTH=8, a=8'hA5, b=8'h3C -> sout 0,0,1,0,0,1,0,0, bit_idx 0..7, done after T0+8, result=8'h24.
- Random operands, 1000 operations with random start gaps -> every result equals a & b at capture, done count equals accepted-start count, sout_valid high exactly WIDTH cycles per operation.
